// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder:
//   - state_t      : responder FSM states (IDLE / WAIT / RESP)
//   - F3_*         : Funct3 encodings for loads and stores
//   - lane_mask_t  : one enable bit per byte lane of a 32-bit word
//   - byte_lane()  : one-hot lane mask for a byte offset
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Funct3 encodings; stores use only the B/H/W codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] lane_mask_t;

    function automatic lane_mask_t byte_lane(input logic [1:0] ofs);
        return lane_mask_t'(4'b0001 << ofs);
    endfunction

endpackage

// File: rtl/ldst_align.sv
// -----------------------------------------------------------------------------
// ldst_align
// Combinational size/offset logic for one data access.
//   is_store   in  : 1 = store, 0 = load
//   funct3     in  : access size and signedness
//   adr_lo     in  : byte offset within the word (address bits 1:0)
//   wdata      in  : right-justified store data
//   rdata      in  : raw SRAM word being loaded from
//   byte_en    out : lanes to write (all zero for loads and faulting accesses)
//   wdata_rep  out : store data replicated onto every lane it may land in
//   load_data  out : extracted and extended load value (zero on fault)
//   fault      out : illegal Funct3, or misaligned when
//                    DMEM_MISALIGN_FAULT_EN is defined
// -----------------------------------------------------------------------------
import dmem_pkg::*;

module ldst_align (
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  adr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output lane_mask_t  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        fault
);

    logic       illegal_s;
    logic       misalign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Classify the access: unsupported Funct3 code and optional misalignment
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B, F3_H, F3_W: illegal_s = 1'b0;
                default:          illegal_s = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
                default:                        illegal_s = 1'b1;
            endcase
        end
`ifdef DMEM_MISALIGN_FAULT_EN
        case (funct3[1:0])
            2'b01:   misalign_s = adr_lo[0];
            2'b10:   misalign_s = (adr_lo != 2'b00);
            default: misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
    end

    assign fault = illegal_s | misalign_s;

    // Store lane enables and data replication; halfwords pick lanes by adr_lo[1] only
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en   = byte_lane(adr_lo);
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = adr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
        if (!is_store || fault) begin
            byte_en = 4'b0000;
        end else begin
            byte_en = byte_en;
        end
    end

    // Select the addressed byte/halfword out of the raw word
    always_comb begin
        case (adr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = adr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected field; faulting accesses return zero
    always_comb begin
        load_data = 32'h0000_0000;
        if (fault) begin
            load_data = 32'h0000_0000;
        end else begin
            case (funct3)
                F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
                F3_H:    load_data = {{16{half_s[15]}}, half_s};
                F3_W:    load_data = rdata;
                F3_BU:   load_data = {24'h00_0000, byte_s};
                F3_HU:   load_data = {16'h0000, half_s};
                default: load_data = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-port responder: accepts one load/store, waits WAIT cycles, performs the
// access on the edge entering RESP and pulses RspValid for one cycle.
// Parameters: WORDS (SRAM depth in words, power of two), WAIT (0..15).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   MemReq, MemWrite      : request valid, store(1)/load(0)
//   Funct3, IEUAdr        : access size/sign, byte address
//   WriteData             : right-justified store data
//   Ready, Stall          : can accept now / core must hold
//   RspValid, LoadResult  : response strobe, extended load data
//   Fault                 : access rejected (valid with RspValid)
// Optional feature macro: DMEM_MISALIGN_FAULT_EN (misaligned accesses fault;
// handled inside ldst_align).
// -----------------------------------------------------------------------------
import dmem_pkg::*;

module dmem_responder #(
    parameter int WORDS = 1024,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] IEUAdr,
    input  logic [31:0] WriteData,
    output logic        Ready,
    output logic        Stall,
    output logic        RspValid,
    output logic [31:0] LoadResult,
    output logic        Fault
);

    localparam int         AW       = $clog2(WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic            we_r;
    logic [2:0]      f3_r;
    logic [AW+1:0]   adr_r;
    logic [31:0]     wd_r;
    logic [31:0]     mem_r [WORDS];

    logic            accept_s;
    logic            access_s;
    logic            acc_we_s;
    logic [2:0]      acc_f3_s;
    logic [AW+1:0]   acc_adr_s;
    logic [31:0]     acc_wd_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     rdata_s;
    lane_mask_t      byte_en_s;
    logic [31:0]     wdata_rep_s;
    logic [31:0]     load_data_s;
    logic            fault_s;
    logic            unused_adr_s;

    // Upper address bits wrap away by design
    assign unused_adr_s = ^IEUAdr[31:AW+2];

    assign accept_s = (state_r == ST_IDLE) && MemReq;
    assign Ready    = (state_r == ST_IDLE);
    assign Stall    = ((state_r == ST_IDLE) && MemReq) || (state_r == ST_WAIT);

    // Access edge: straight from IDLE when WAIT is 0, else when the count expires
    always_comb begin
        access_s = 1'b0;
        if (state_r == ST_IDLE) begin
            access_s = accept_s && (WAIT == 0);
        end else if (state_r == ST_WAIT) begin
            access_s = (cnt_r == 4'd0);
        end else begin
            access_s = 1'b0;
        end
    end

    // With WAIT=0 the request registers are not loaded yet, so use live inputs
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s  = MemWrite;
            acc_f3_s  = Funct3;
            acc_adr_s = IEUAdr[AW+1:0];
            acc_wd_s  = WriteData;
        end else begin
            acc_we_s  = we_r;
            acc_f3_s  = f3_r;
            acc_adr_s = adr_r;
            acc_wd_s  = wd_r;
        end
    end

    assign idx_s   = acc_adr_s[AW+1:2];
    assign rdata_s = mem_r[idx_s];

    ldst_align u_align (
        .is_store  (acc_we_s),
        .funct3    (acc_f3_s),
        .adr_lo    (acc_adr_s[1:0]),
        .wdata     (acc_wd_s),
        .rdata     (rdata_s),
        .byte_en   (byte_en_s),
        .wdata_rep (wdata_rep_s),
        .load_data (load_data_s),
        .fault     (fault_s)
    );

    // FSM, wait counter and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            adr_r   <= '0;
            wd_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r  <= MemWrite;
                        f3_r  <= Funct3;
                        adr_r <= IEUAdr[AW+1:0];
                        wd_r  <= WriteData;
                        if (WAIT == 0) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Response registers; LoadResult/Fault hold until the next access edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RspValid   <= 1'b0;
            LoadResult <= 32'h0000_0000;
            Fault      <= 1'b0;
        end else begin
            RspValid <= access_s;
            if (access_s) begin
                LoadResult <= acc_we_s ? 32'h0000_0000 : load_data_s;
                Fault      <= fault_s;
            end
        end
    end

    // SRAM byte-lane write; contents are never reset, a reset edge blocks the write
    always_ff @(posedge clk) begin
        if (access_s && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (WAIT = 0, 1, 3) share stimulus; a byte-addressed reference
// memory predicts load data, faults, latency and Stall/Ready per cycle.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] ieu_adr;
    logic [31:0] write_data;
    logic [2:0]  rdy, stl, rsp, flt;
    logic [31:0] lr [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ref_mem [4096];

    always #5 clk = ~clk;

    dmem_responder #(.WORDS(1024), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .MemReq(req[0]), .MemWrite(mem_write), .Funct3(funct3),
        .IEUAdr(ieu_adr), .WriteData(write_data), .Ready(rdy[0]), .Stall(stl[0]),
        .RspValid(rsp[0]), .LoadResult(lr[0]), .Fault(flt[0]));
    dmem_responder #(.WORDS(1024), .WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .MemReq(req[1]), .MemWrite(mem_write), .Funct3(funct3),
        .IEUAdr(ieu_adr), .WriteData(write_data), .Ready(rdy[1]), .Stall(stl[1]),
        .RspValid(rsp[1]), .LoadResult(lr[1]), .Fault(flt[1]));
    dmem_responder #(.WORDS(1024), .WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .MemReq(req[2]), .MemWrite(mem_write), .Funct3(funct3),
        .IEUAdr(ieu_adr), .WriteData(write_data), .Ready(rdy[2]), .Stall(stl[2]),
        .RspValid(rsp[2]), .LoadResult(lr[2]), .Fault(flt[2]));

    function automatic int wv(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: byte memory, modulo 4 KiB, little-endian fields aligned down to size
    task automatic ref_access(input bit we, input bit [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output bit fault, output logic [31:0] data);
        int addr, size, base;
        logic [31:0] v;
        addr  = int'(a % 32'd4096);
        size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        fault = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_FAULT_EN
        if ((addr % size) != 0) fault = 1'b1;
`endif
        base = addr - (addr % size);
        data = 32'h0;
        if (fault) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            data = v;
        end
    endtask

    // One request to the DUTs in mask; checks every cycle up to 8 after accept
    task automatic do_op(input bit we, input bit [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] mask,
                         output logic [31:0] res1, output logic flt1);
        bit          ef;
        logic [31:0] ed;
        int          w;
        ref_access(we, f3, a, wd, ef, ed);
        res1 = 32'h0; flt1 = 1'b0;
        mem_write = we; funct3 = f3; ieu_adr = a; write_data = wd; req = mask;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                check($sformatf("stall%0d_c0", k), stl[k], 1);
                check($sformatf("ready%0d_c0", k), rdy[k], 1);
            end
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req = 3'b000;
                mem_write = 1'($urandom); funct3 = 3'($urandom);
                ieu_adr = $urandom; write_data = $urandom;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    w = wv(k);
                    check($sformatf("rsp%0d_c%0d", k, c), rsp[k], (c == w + 1) ? 1 : 0);
                    check($sformatf("stall%0d_c%0d", k, c), stl[k], (c <= w) ? 1 : 0);
                    check($sformatf("ready%0d_c%0d", k, c), rdy[k], (c > w + 1) ? 1 : 0);
                    if (c == w + 1) begin
                        check($sformatf("fault%0d@%h", k, a), flt[k], ef);
                        if (!we || ef) check($sformatf("data%0d@%h", k, a), lr[k], ed);
                        if (k == 1) begin res1 = lr[1]; flt1 = flt[1]; end
                    end
                    if (c == 8 && (!we || ef)) check($sformatf("hold%0d@%h", k, a), lr[k], ed);
                end
            end
        end
    endtask

    logic [31:0] r;
    logic        f;
    bit          ef;
    logic [31:0] ed;

    initial begin
        reset = 1'b1; req = 3'b111; mem_write = 1'b0; funct3 = 3'b010;
        ieu_adr = 32'h0; write_data = 32'h0;
        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_rsp%0d", k), rsp[k], 0);
            check($sformatf("rst_lr%0d", k), lr[k], 0);
            check($sformatf("rst_flt%0d", k), flt[k], 0);
            check($sformatf("rst_rdy%0d", k), rdy[k], 1);
            check($sformatf("rst_stl_req%0d", k), stl[k], 1);
        end
        req = 3'b000; #1;
        for (int k = 0; k < 3; k++) check($sformatf("rst_stl_noreq%0d", k), stl[k], 0);
        @(posedge clk); #1; reset = 1'b0;

        // Word store/load
        do_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 3'b111, r, f);
        do_op(0, 3'b010, 32'h100, 32'h0, 3'b111, r, f);
        check("lw100", r, 32'hDEADBEEF); check("lw100_flt", f, 0);
        // Byte store, signed/unsigned byte loads
        do_op(1, 3'b000, 32'h103, 32'h80, 3'b111, r, f);
        do_op(0, 3'b000, 32'h103, 32'h0, 3'b111, r, f); check("lb103", r, 32'hFFFFFF80);
        do_op(0, 3'b100, 32'h103, 32'h0, 3'b111, r, f); check("lbu103", r, 32'h00000080);
        do_op(0, 3'b010, 32'h100, 32'h0, 3'b111, r, f); check("lw_after_sb", r, 32'h80ADBEEF);
        // Halfword store/loads
        do_op(1, 3'b001, 32'h102, 32'h8001, 3'b111, r, f);
        do_op(0, 3'b001, 32'h102, 32'h0, 3'b111, r, f); check("lh102", r, 32'hFFFF8001);
        do_op(0, 3'b101, 32'h102, 32'h0, 3'b111, r, f); check("lhu102", r, 32'h00008001);
        do_op(0, 3'b010, 32'h100, 32'h0, 3'b111, r, f); check("lw_after_sh", r, 32'h8001BEEF);
        // Misaligned word accesses
        do_op(0, 3'b010, 32'h101, 32'h0, 3'b111, r, f);
`ifdef DMEM_MISALIGN_FAULT_EN
        check("lw101_flt", f, 1); check("lw101_data", r, 32'h0);
`else
        check("lw101_flt", f, 0); check("lw101_data", r, 32'h8001BEEF);
`endif
        do_op(1, 3'b010, 32'h101, 32'h55555555, 3'b111, r, f);
        do_op(0, 3'b010, 32'h100, 32'h0, 3'b111, r, f);
`ifdef DMEM_MISALIGN_FAULT_EN
        check("sw101_nowrite", r, 32'h8001BEEF);
`else
        check("sw101_write", r, 32'h55555555);
`endif
        // Illegal Funct3
        do_op(0, 3'b011, 32'h100, 32'h0, 3'b111, r, f);
        check("ill_ld_flt", f, 1); check("ill_ld_data", r, 32'h0);
        do_op(1, 3'b100, 32'h100, 32'hFFFFFFFF, 3'b111, r, f); check("ill_st_flt", f, 1);

        // Reset during WAIT discards the store (WAIT=1 DUT only)
        do_op(1, 3'b010, 32'h200, 32'hCAFEF00D, 3'b111, r, f);
        mem_write = 1'b1; funct3 = 3'b010; ieu_adr = 32'h200; write_data = 32'h12345678; req = 3'b010;
        @(posedge clk); #1;
        req = 3'b000; reset = 1'b1; #1;
        check("midrst_rdy", rdy[1], 1); check("midrst_rsp", rsp[1], 0);
        #1; reset = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk); #2;
            check($sformatf("midrst_norsp_c%0d", c), rsp[1], 0);
            check($sformatf("midrst_ready_c%0d", c), rdy[1], 1);
        end
        do_op(0, 3'b010, 32'h200, 32'h0, 3'b111, r, f); check("lw200_prior", r, 32'hCAFEF00D);

        // MemReq held: RESP ignores it, next accept one cycle later
        ref_access(0, 3'b010, 32'h100, 32'h0, ef, ed);
        mem_write = 1'b0; funct3 = 3'b010; ieu_adr = 32'h100; req = 3'b010;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 6) req = 3'b000;
            #1;
            check($sformatf("held_rsp_c%0d", c), rsp[1], (c == 2 || c == 5) ? 1 : 0);
            if (c == 2 || c == 5) begin
                check($sformatf("held_rdy_c%0d", c), rdy[1], 0);
                check($sformatf("held_stl_c%0d", c), stl[1], 0);
                check($sformatf("held_data_c%0d", c), lr[1], ed);
            end
        end

        // Randomized traffic over a pre-initialised region with random upper address bits
        for (int i = 0; i < 16; i++) do_op(1, 3'b010, 32'h300 + 32'(4 * i), $urandom, 3'b111, r, f);
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 3'($urandom),
                  ($urandom & 32'hFFFFF000) | 32'h300 | 32'($urandom_range(0, 63)),
                  $urandom, 3'b111, r, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data port of the integer datapath. It accepts load/store requests driven from the datapath's `IEUAdr` and `WriteData` outputs and owns a word-organised data SRAM. It performs byte/halfword/word stores with lane steering, and returns a sign- or zero-extended `LoadResult` after a parameterised number of wait states. It sits between the datapath and the data storage, and holds the core with `Stall` until each access completes.

## Interface
- `WORDS`, 1024: SRAM depth in 32-bit words; power of two.
- `WAIT`, 1: wait-state cycles between request accept and the access; legal range 0–15.

- `clk` in 1: single clock; everything updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `MemReq` in 1: request valid.
- `MemWrite` in 1: 1 = store, 0 = load.
- `Funct3` in 3: size and sign of the access.
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
- `IEUAdr` in 32: byte address.
- `WriteData` in 32: store data, right-justified.
- `Ready` out 1: can accept a request this cycle.
- `Stall` out 1: core must hold its state this cycle.
- `RspValid` out 1: one-cycle response strobe.
- `LoadResult` out 32: extended load data; valid while `RspValid` is high.
- `Fault` out 1: access rejected; valid while `RspValid` is high.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `Ready` = 1.
  - A request is accepted when `MemReq` && `Ready`.
  - On accept, register `IEUAdr`, `WriteData`, `MemWrite` and `Funct3`. Inputs may change freely after the accept edge.
  - On accept, go to WAIT with the counter loaded to `WAIT`-1. If `WAIT`=0, go directly to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - At counter 0, go to RESP.
- Access: performed on the edge entering RESP.
  - Stores write the selected byte lanes.
  - Loads register the extracted word into `LoadResult`.
- RESP:
  - `RspValid` = 1 for exactly one cycle, then go to IDLE.
  - `MemReq` in RESP is ignored (`Ready` = 0).
- `Stall` = (IDLE && `MemReq`) || WAIT. `Stall` is 0 in RESP, so the core advances on the response cycle.
- Word index: `IEUAdr[log2(WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo WORDS*4.
- Store lanes:
  - sb: lane `Adr[1:0]` gets `WriteData[7:0]`.
  - sh: lanes {`Adr[1]`,0} and {`Adr[1]`,1} get `WriteData[15:0]`.
  - sw: all four lanes.
- Load extract:
  - Bytes and halfwords are selected with the same lane rules as stores.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Illegal `Funct3` (load 011/110/111; store with `Funct3[2]`=1 or 011): no write, `LoadResult` = 0, `Fault` = 1 in RESP.
- SRAM contents are not reset.

## Timing
- Accept in cycle 0; `RspValid` in cycle `WAIT`+1.
  - `WAIT`=0 gives a 1-cycle latency.
  - Back-to-back requests issue at most once every `WAIT`+2 cycles.
- Reset values:
  - State IDLE, counter 0.
  - `RspValid` 0, `LoadResult` 0, `Fault` 0.
  - `Ready` 1.
  - `Stall` follows `MemReq`.
- Reset mid-operation (WAIT or RESP):
  - Return to IDLE immediately.
  - A store not yet written is discarded; no `RspValid` pulse.
- `LoadResult` and `Fault` hold their values after RESP until the next access edge.

## Configuration
- `DMEM_MISALIGN_FAULT_EN` defined:
  - Misaligned accesses are faults: lh/lhu/sh with `Adr[0]`=1, or lw/sw with `Adr[1:0]`≠0.
  - On a fault: no write, `LoadResult` = 0, `Fault` = 1 in RESP.
- Not defined:
  - No alignment check.
  - Halfwords use `Adr[1]` only; words ignore `Adr[1:0]`.
  - `Fault` is raised only for illegal `Funct3`.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - `Funct3` encoding constants;
  - the lane-mask type.
- Sub-module `ldst_align` (combinational) holds the `Funct3`/`Adr[1:0]` logic:
  - byte-enable and store-data replication;
  - load extraction and extension;
  - illegal/misalign detection.
- The top level contains the FSM, wait counter, request registers and SRAM array.

## Test plan
- Reset, then sw 0xDEADBEEF @0x100, then lw @0x100 (`WAIT`=1).
  - `Stall` high in cycles 0–1; `RspValid` in cycle 2.
  - `LoadResult` = 0xDEADBEEF, `Fault` = 0.
- sb 0x80 @0x103, then loads:
  - lb @0x103 → 0xFFFFFF80;
  - lbu @0x103 → 0x00000080;
  - lw @0x100 → 0x80ADBEEF.
- sh 0x8001 @0x102, then loads:
  - lh @0x102 → 0xFFFF8001;
  - lhu @0x102 → 0x00008001;
  - lw @0x100 → 0x8001BEEF.
- lw @0x101:
  - with `DMEM_MISALIGN_FAULT_EN`: `Fault` = 1, `LoadResult` = 0.
  - without it: `LoadResult` = word @0x100, `Fault` = 0.
  - sw @0x101 with the macro leaves the word @0x100 unchanged.
- sw 0x12345678 @0x200, with `reset` pulsed in the WAIT cycle.
  - No `RspValid` pulse; `Ready` = 1 after reset.
  - lw @0x200 returns the prior contents.
- Latency and ignored requests:
  - `WAIT`=0: lw responds in cycle 1.
  - `WAIT`=3: lw responds in cycle 4.
  - `MemReq` held through RESP is not accepted until the following IDLE cycle.
  - Illegal `Funct3`=011 gives `Fault` = 1.
